// File: rtl/mem_responder_if.sv
// CPU-to-memory request/complete bundle: MAR/MDR-side request signals plus
// the completion strobe, alignment error and read data returned to the CPU.
interface mem_responder_if;
  logic        MOV;
  logic        RW;
  logic [1:0]  DT;
  logic [31:0] ADDR;
  logic [31:0] DIN;
  logic [31:0] DOUT;
  logic        MFC;
  logic        ERR;

  modport master (
    output MOV, RW, DT, ADDR, DIN,
    input  DOUT, MFC, ERR
  );

  modport slave (
    input  MOV, RW, DT, ADDR, DIN,
    output DOUT, MFC, ERR
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-addressed big-endian memory responder: captures a request on MOV, waits
// WAIT_CYCLES, performs the access, then holds MFC until the CPU drops MOV.
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RSTn,
  mem_responder_if.slave  bus
);

  localparam int CW    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic [1:0]             dt_q, dt_d;
  logic [31:0]            din_q, din_d;
  logic [31:0]            dout_q, dout_d;
  logic                   mfc_q, mfc_d;
  logic                   err_q, err_d;

  logic [7:0]             mem_q [DEPTH];
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   a1, a2, a3;
  logic [31:0]            rd_word;
  logic [31:0]            rd_sized;
  logic                   misal;
  logic                   unused_addr;

  assign unused_addr = ^bus.ADDR[31:ADDR_BITS];

  // Byte offsets wrap inside the array; aligned accesses never reach the wrap.
  assign a1 = addr_q + ADDR_BITS'(1);
  assign a2 = addr_q + ADDR_BITS'(2);
  assign a3 = addr_q + ADDR_BITS'(3);

  assign rd_word = {mem_q[addr_q], mem_q[a1], mem_q[a2], mem_q[a3]};

  always_comb begin
    rd_sized = rd_word;
    misal    = 1'b0;
    unique case (dt_q)
      2'b00: rd_sized = {24'h0, rd_word[31:24]};
      2'b01: begin
        rd_sized = {16'h0, rd_word[31:16]};
        misal    = addr_q[0];
      end
      default: misal = |addr_q[1:0];
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      dt_q    <= 2'b00;
      din_q   <= '0;
      dout_q  <= '0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      dt_q    <= dt_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    dt_d    = dt_q;
    din_d   = din_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.MOV) begin
          addr_d  = bus.ADDR[ADDR_BITS-1:0];
          rw_d    = bus.RW;
          dt_d    = bus.DT;
          din_d   = bus.DIN;
          cnt_d   = CW'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          mfc_d   = 1'b1;
          state_d = DONE;
          if (misal) begin
            err_d  = 1'b1;
            dout_d = '0;
          end else begin
            err_d = 1'b0;
            if (rw_q) dout_d = rd_sized;
            else      mem_we = 1'b1;
          end
        end
      end
      DONE: begin
        // DOUT intentionally survives the return to IDLE.
        if (!bus.MOV) begin
          mfc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage is not reset; mem_we is gated by state_q, which reset forces to IDLE.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      unique case (dt_q)
        2'b00: mem_q[addr_q] <= din_q[7:0];
        2'b01: begin
          mem_q[addr_q] <= din_q[15:8];
          mem_q[a1]     <= din_q[7:0];
        end
        default: begin
          mem_q[addr_q] <= din_q[31:24];
          mem_q[a1]     <= din_q[23:16];
          mem_q[a2]     <= din_q[15:8];
          mem_q[a3]     <= din_q[7:0];
        end
      endcase
    end
  end

  assign bus.DOUT = dout_q;
  assign bus.MFC  = mfc_q;
  assign bus.ERR  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance driven by
// directed and random requests, checked against a byte-array reference model.
module tb_mem_responder;

  logic CLK;
  logic RSTn;

  logic        mov_t  [2];
  logic        rw_t   [2];
  logic [1:0]  dt_t   [2];
  logic [31:0] addr_t [2];
  logic [31:0] din_t  [2];
  logic [31:0] dout_t [2];
  logic        mfc_t  [2];
  logic        err_t  [2];

  int n_chk;
  int n_err;

  byte unsigned mdl_mem  [2][256];
  logic [31:0]  mdl_dout [2];

  mem_responder_if if0 ();
  mem_responder_if if1 ();

  assign if0.MOV  = mov_t[0];
  assign if0.RW   = rw_t[0];
  assign if0.DT   = dt_t[0];
  assign if0.ADDR = addr_t[0];
  assign if0.DIN  = din_t[0];
  assign dout_t[0] = if0.DOUT;
  assign mfc_t[0]  = if0.MFC;
  assign err_t[0]  = if0.ERR;

  assign if1.MOV  = mov_t[1];
  assign if1.RW   = rw_t[1];
  assign if1.DT   = dt_t[1];
  assign if1.ADDR = addr_t[1];
  assign if1.DIN  = din_t[1];
  assign dout_t[1] = if1.DOUT;
  assign mfc_t[1]  = if1.MFC;
  assign err_t[1]  = if1.ERR;

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut_w2 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (if0)
  );

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut_w0 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (if1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int wait_of(int inst);
    return (inst == 0) ? 2 : 0;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: size in bytes, big-endian byte order, address taken modulo 256.
  task automatic model_op(int inst, bit rw, bit [1:0] dt, bit [31:0] addr, bit [31:0] din,
                          output logic [31:0] exp_dout, output logic exp_err);
    int size;
    int a;
    logic [31:0] v;
    size = (dt == 2'd0) ? 1 : (dt == 2'd1) ? 2 : 4;
    a    = int'(addr % 256);
    if ((a % size) != 0) begin
      exp_err  = 1'b1;
      exp_dout = 32'h0;
    end else begin
      exp_err = 1'b0;
      if (rw) begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = (v << 8) | 32'(mdl_mem[inst][(a + i) % 256]);
        exp_dout = v;
      end else begin
        for (int i = 0; i < size; i++)
          mdl_mem[inst][(a + i) % 256] = byte'(din >> (8 * (size - 1 - i)));
        exp_dout = mdl_dout[inst];
      end
    end
    mdl_dout[inst] = exp_dout;
  endtask

  task automatic do_op(int inst, bit rw, bit [1:0] dt, bit [31:0] addr, bit [31:0] din,
                       bit check, int hold);
    logic [31:0] exp_dout;
    logic        exp_err;
    int          n;
    model_op(inst, rw, dt, addr, din, exp_dout, exp_err);
    @(negedge CLK);
    rw_t[inst]   = rw;
    dt_t[inst]   = dt;
    addr_t[inst] = addr;
    din_t[inst]  = din;
    mov_t[inst]  = 1'b1;
    @(negedge CLK);
    n = 0;
    if (check) chk("mfc_at_capture", 32'(mfc_t[inst]), 32'd0);
    while (!mfc_t[inst] && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (check) begin
      chk("latency", 32'(n), 32'(wait_of(inst) + 1));
      chk("err", 32'(err_t[inst]), 32'(exp_err));
      chk("dout", dout_t[inst], exp_dout);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("mfc_hold", 32'(mfc_t[inst]), 32'd1);
      chk("dout_hold", dout_t[inst], exp_dout);
    end
    mov_t[inst] = 1'b0;
    rw_t[inst]  = ($urandom_range(0, 1) == 1);
    din_t[inst] = $urandom;
    @(negedge CLK);
    if (check) begin
      chk("mfc_clear", 32'(mfc_t[inst]), 32'd0);
      chk("err_clear", 32'(err_t[inst]), 32'd0);
      chk("dout_keep", dout_t[inst], exp_dout);
    end
  endtask

  initial begin
    logic [31:0] seen;
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 2; i++) begin
      mov_t[i] = 1'b0; rw_t[i] = 1'b0; dt_t[i] = 2'b00;
      addr_t[i] = 32'h0; din_t[i] = 32'h0; mdl_dout[i] = 32'h0;
    end
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk("rst_mfc", 32'(mfc_t[i]), 32'd0);
      chk("rst_err", 32'(err_t[i]), 32'd0);
      chk("rst_dout", dout_t[i], 32'h0);
    end

    // Fill both arrays so every later read has a known reference value.
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a += 4)
        do_op(i, 1'b0, 2'b10, 32'(a), $urandom, 1'b0, 0);

    do_op(0, 1'b0, 2'b10, 32'h10, 32'h11223344, 1'b1, 0);
    do_op(0, 1'b1, 2'b10, 32'h10, 32'h0, 1'b1, 0);
    chk("word_rd_const", dout_t[0], 32'h11223344);
    do_op(0, 1'b1, 2'b00, 32'h11, 32'h0, 1'b1, 0);
    chk("byte_rd_const", dout_t[0], 32'h00000022);
    do_op(0, 1'b1, 2'b01, 32'h12, 32'h0, 1'b1, 0);
    chk("half_rd_const", dout_t[0], 32'h00003344);
    do_op(0, 1'b0, 2'b00, 32'h13, 32'hFFFFFFAA, 1'b1, 0);
    do_op(0, 1'b1, 2'b11, 32'h10, 32'h0, 1'b1, 0);
    chk("byte_wr_const", dout_t[0], 32'h112233AA);

    seen = {mdl_mem[0][32], mdl_mem[0][33], mdl_mem[0][34], mdl_mem[0][35]};
    do_op(0, 1'b0, 2'b10, 32'h21, 32'hDEADBEEF, 1'b1, 0);
    do_op(0, 1'b1, 2'b10, 32'h20, 32'h0, 1'b1, 0);
    chk("misal_no_write", dout_t[0], seen);

    do_op(0, 1'b0, 2'b01, 32'h40, 32'h0000A55A, 1'b1, 5);
    do_op(0, 1'b1, 2'b10, 32'h40, 32'h0, 1'b1, 5);

    // Abort a write two cycles into BUSY.
    seen = {mdl_mem[0][48], mdl_mem[0][49], mdl_mem[0][50], mdl_mem[0][51]};
    @(negedge CLK);
    rw_t[0] = 1'b0; dt_t[0] = 2'b10; addr_t[0] = 32'h30; din_t[0] = 32'hCAFEF00D;
    mov_t[0] = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("rst_mid_mfc", 32'(mfc_t[0]), 32'd0);
    chk("rst_mid_dout", dout_t[0], 32'h0);
    mov_t[0] = 1'b0;
    mdl_dout[0] = 32'h0;
    mdl_dout[1] = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    do_op(0, 1'b1, 2'b10, 32'h30, 32'h0, 1'b1, 0);
    chk("rst_no_write", dout_t[0], seen);

    do_op(1, 1'b0, 2'b10, 32'h104, 32'h5A6B7C8D, 1'b1, 0);
    do_op(1, 1'b1, 2'b10, 32'h004, 32'h0, 1'b1, 0);
    chk("alias_const", dout_t[1], 32'h5A6B7C8D);

    for (int k = 0; k < 400; k++)
      do_op(k % 2, ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
            (($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255))),
            $urandom, 1'b1, (($urandom_range(0, 7) == 0) ? 2 : 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's MAR/MDR memory interface.
- Accepts a request strobe plus address (from MAR), write data (from MDR), direction and data type, then completes it after a programmable number of wait cycles.
- Completion is signalled by asserting MFC (memory function complete); read data is driven back toward the MDR load path.
- Byte-addressed, big-endian, synchronous storage array inside the block.

Parameters:
ADDR_BITS, 8, byte-address width actually decoded; array size is 2**ADDR_BITS bytes; upper ADDR bits ignored.
WAIT_CYCLES, 2, extra cycles between request capture and access/completion (0 legal).

Ports:
CLK  input  1  single system clock, all state on rising edge
RSTn  input  1  asynchronous active-low reset
MOV  input  1  memory operation valid; request strobe held high until MFC seen
RW  input  1  1 = read, 0 = write
DT  input  2  data type: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
ADDR  input  32  byte address (MAR output)
DIN  input  32  write data (MDR output); byte uses [7:0], halfword uses [15:0]
DOUT  output  32  read data toward MDR input, registered
MFC  output  1  operation complete, registered
ERR  output  1  alignment error, valid while MFC=1

Behaviour:
- Reset (RSTn low, asynchronous): state IDLE, MFC=0, ERR=0, DOUT=0, wait counter=0. Storage array contents are not cleared. Reset mid-operation aborts the request; a pending write is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On an edge with MOV=1, capture ADDR[ADDR_BITS-1:0], RW, DT and DIN.
  - Load the counter with WAIT_CYCLES and go to BUSY.
  - Inputs are ignored after capture until the next IDLE.
- BUSY:
  - Counter nonzero: decrement.
  - Counter zero: perform the access on this edge, set MFC=1, go to DONE.
  - MOV dropping during BUSY does not cancel the access.
- Latency: MOV captured at edge k → MFC high after edge k+1+WAIT_CYCLES. Default is 3 cycles; WAIT_CYCLES=0 gives 1 cycle.
- DONE: MFC, ERR and DOUT are held while MOV=1. The first edge with MOV=0 clears MFC and ERR and returns to IDLE. DOUT holds its last value. A new request needs at least one IDLE cycle with MOV sampled there.
- Alignment:
  - Halfword requires ADDR[0]=0; word requires ADDR[1:0]=00.
  - Misaligned request: no array write, DOUT=0, ERR=1 with MFC.
- Read:
  - Big-endian: lowest address is the most significant byte.
  - Byte is zero-extended into DOUT[7:0].
  - Halfword is {mem[a],mem[a+1]} zero-extended into DOUT[15:0].
  - Word is {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
- Write:
  - Byte: mem[a]=DIN[7:0].
  - Halfword: mem[a]=DIN[15:8], mem[a+1]=DIN[7:0].
  - Word: mem[a..a+3]=DIN[31:24]..DIN[7:0].
  - DOUT is unchanged on write. ERR=0 on aligned access.
- Address wrap: only the low ADDR_BITS bits are decoded, so address 0x100 aliases 0x000 at default ADDR_BITS=8. Aligned accesses never cross the array end.
- DT=11 behaves exactly as word.

Test Plan:
- Word write then read: write ADDR=0x10, DIN=0x11223344, DT=10; then read ADDR=0x10 DT=10 → DOUT=0x11223344; MFC rises 3 cycles after MOV capture each time, ERR=0.
- Byte/halfword sizing: after the word above, read byte ADDR=0x11 → DOUT=0x00000022; read halfword ADDR=0x12 → DOUT=0x00003344; write byte ADDR=0x13 DIN=0xFFFFFFAA, then read word 0x10 → 0x112233AA.
- Misalignment: write word ADDR=0x21 DIN=0xDEADBEEF → MFC=1, ERR=1; read word 0x20 → prior contents unchanged, ERR=0.
- Handshake hold: keep MOV high 5 cycles after MFC → MFC stays 1 and no second access occurs; drop MOV → MFC=0 next edge; next request starts from IDLE.
- Reset mid-write: issue write ADDR=0x30 DIN=0xCAFEF00D, pull RSTn low during BUSY → MFC=0, DOUT=0 immediately; read 0x30 after reset → old contents, write not performed.
- WAIT_CYCLES=0 instance plus address alias: MFC one cycle after capture; write word 0x104 then read 0x004 → same data.
